// File: rtl/cnn_layer_accel_pack_pkg.sv
// Shared types and constants for the CNN result packer.
// Holds the packer FSM state enum, lane/width constants, the packed
// output word carried through the output FIFO, and the optional sample
// rectifier (enabled by defining CNN_RESULT_PACKER_RELU_EN).
package cnn_layer_accel_pack_pkg;

  localparam int unsigned C_RES_WIDTH  = 16;
  localparam int unsigned C_LANES      = 8;
  localparam int unsigned C_CNT_WIDTH  = 32;
  localparam int unsigned C_PACK_WIDTH = C_RES_WIDTH * C_LANES;
  localparam int unsigned C_LANE_IDX_W = $clog2(C_LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } pack_state_t;

  typedef struct packed {
    logic [C_PACK_WIDTH-1:0] data;
    logic [C_LANES-1:0]      keep;
    logic                    last;
  } pack_word_t;

  // Optional rectification: negative samples become zero.
  function automatic logic [C_RES_WIDTH-1:0] rectify(input logic [C_RES_WIDTH-1:0] s);
`ifdef CNN_RESULT_PACKER_RELU_EN
    return s[C_RES_WIDTH-1] ? C_RES_WIDTH'(0) : s;
`else
    return s;
`endif
  endfunction

endpackage

// File: rtl/cnn_layer_accel_pack_fifo.sv
// Two-entry output FIFO of packed words, built as a registered head stage
// plus one skid entry so the visible word and its flags come from flops.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_word   write request and word (ignored when full and not popping)
//   pop               read request (ignored when empty)
//   head              oldest word, held stable until popped
//   valid             FIFO not empty (head is valid)
//   full              both entries occupied
module cnn_layer_accel_pack_fifo
  import cnn_layer_accel_pack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pack_word_t push_word,
  input  logic       pop,
  output pack_word_t head,
  output logic       valid,
  output logic       full
);

  pack_word_t head_q;
  pack_word_t tail_q;
  logic       head_v;
  logic       tail_v;
  logic       do_pop;
  logic       do_push;

  // A push on a full FIFO is allowed only when the head leaves this cycle.
  assign do_pop  = pop & head_v;
  assign do_push = push & (~tail_v | do_pop);

  // Entry storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      head_v <= 1'b0;
      tail_v <= 1'b0;
    end else if (do_pop) begin
      if (tail_v) begin
        head_q <= tail_q;
        tail_v <= do_push;
        if (do_push) tail_q <= push_word;
      end else begin
        head_v <= do_push;
        if (do_push) head_q <= push_word;
      end
    end else if (do_push) begin
      if (!head_v) begin
        head_q <= push_word;
        head_v <= 1'b1;
      end else begin
        tail_q <= push_word;
        tail_v <= 1'b1;
      end
    end
  end

  assign head  = head_q;
  assign valid = head_v;
  assign full  = tail_v;

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs a job's 16-bit convolution results eight to a 128-bit word,
// zero-pads the final partial word, marks it last, and reports job
// completion with a done/ack handshake.
// Optional feature: define CNN_RESULT_PACKER_RELU_EN to zero negative samples.
// Ports:
//   clk_if, rst                      clock, async active-low reset
//   cfg_valid, cfg_num_results       job start pulse and result count
//   cfg_accept                       high while idle
//   result_valid/result_accept/data  incoming sample stream
//   pack_valid/pack_ready            outgoing word handshake
//   pack_data, pack_keep, pack_last  outgoing word payload
//   job_done, job_done_ack           completion level and its clear
module cnn_layer_accel_result_packer
  import cnn_layer_accel_pack_pkg::*;
(
  input  logic         clk_if,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [31:0]  cfg_num_results,
  output logic         cfg_accept,
  input  logic         result_valid,
  output logic         result_accept,
  input  logic [15:0]  result_data,
  output logic         pack_valid,
  input  logic         pack_ready,
  output logic [127:0] pack_data,
  output logic [7:0]   pack_keep,
  output logic         pack_last,
  output logic         job_done,
  input  logic         job_done_ack
);

  pack_state_t             state_q;
  pack_state_t             state_d;
  logic [C_LANE_IDX_W-1:0] lane_q;
  logic [C_CNT_WIDTH-1:0]  remaining_q;
  logic [C_PACK_WIDTH-1:0] data_q;
  logic [C_LANES-1:0]      keep_q;
  logic [C_RES_WIDTH-1:0]  sample_c;
  pack_word_t              word_c;
  pack_word_t              head;
  logic                    fifo_full;
  logic                    take;
  logic                    last_sample;
  logic                    word_done;
  logic                    last_handoff;

  assign result_accept = (state_q == COLLECT) && !fifo_full;
  assign take          = result_valid && result_accept;
  assign last_sample   = (remaining_q == C_CNT_WIDTH'(1));
  assign word_done     = take && ((lane_q == C_LANE_IDX_W'(C_LANES - 1)) || last_sample);
  assign last_handoff  = pack_valid && pack_ready && head.last;
  assign sample_c      = rectify(result_data);

  // Word as it stands once the current sample lands in its lane.
  always_comb begin
    word_c      = '0;
    word_c.data = data_q;
    word_c.data[lane_q * C_RES_WIDTH +: C_RES_WIDTH] = sample_c;
    word_c.keep = keep_q | (C_LANES'(1) << lane_q);
    word_c.last = last_sample;
  end

  // State register.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; FLUSH exits on the edge that hands off the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) state_d = (cfg_num_results == C_CNT_WIDTH'(0)) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (take && last_sample) state_d = FLUSH;
      end
      FLUSH: begin
        if (!pack_valid || last_handoff) state_d = DONE;
      end
      DONE: begin
        if (job_done_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane assembly and result counting.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      lane_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      keep_q      <= '0;
    end else if ((state_q == IDLE) && cfg_valid) begin
      lane_q      <= '0;
      remaining_q <= cfg_num_results;
      data_q      <= '0;
      keep_q      <= '0;
    end else if (take) begin
      if (remaining_q != C_CNT_WIDTH'(0)) remaining_q <= remaining_q - C_CNT_WIDTH'(1);
      if (word_done) begin
        lane_q <= '0;
        data_q <= '0;
        keep_q <= '0;
      end else begin
        lane_q <= lane_q + C_LANE_IDX_W'(1);
        data_q <= word_c.data;
        keep_q <= word_c.keep;
      end
    end
  end

  cnn_layer_accel_pack_fifo u_fifo (
    .clk       (clk_if),
    .rst_n     (rst),
    .push      (word_done),
    .push_word (word_c),
    .pop       (pack_ready),
    .head      (head),
    .valid     (pack_valid),
    .full      (fifo_full)
  );

  assign pack_data  = head.data;
  assign pack_keep  = head.keep;
  assign pack_last  = head.last;
  assign cfg_accept = (state_q == IDLE);
  assign job_done   = (state_q == DONE);

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Self-checking bench for cnn_layer_accel_result_packer: directed and
// randomized jobs compared against a lane-chunking reference model.
module tb_cnn_layer_accel_result_packer;

  logic         clk_if = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [31:0]  cfg_num_results = '0;
  logic         cfg_accept;
  logic         result_valid = 1'b0;
  logic         result_accept;
  logic [15:0]  result_data = '0;
  logic         pack_valid;
  logic         pack_ready = 1'b0;
  logic [127:0] pack_data;
  logic [7:0]   pack_keep;
  logic         pack_last;
  logic         job_done;
  logic         job_done_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [15:0]  smp [0:63];
  logic [15:0]  acc_q[$];
  logic [127:0] out_data[$];
  logic [7:0]   out_keep[$];
  logic         out_last[$];

  logic         stalled = 1'b0;
  logic [127:0] held_data;
  logic [7:0]   held_keep;
  logic         held_last;
  logic         last_hs_prev = 1'b0;
  logic         acc_now;
  logic         obs_done;
  logic         obs_racc;
  logic         obs_cfg_acc;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_result_packer dut (
    .clk_if          (clk_if),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_num_results (cfg_num_results),
    .cfg_accept      (cfg_accept),
    .result_valid    (result_valid),
    .result_accept   (result_accept),
    .result_data     (result_data),
    .pack_valid      (pack_valid),
    .pack_ready      (pack_ready),
    .pack_data       (pack_data),
    .pack_keep       (pack_keep),
    .pack_last       (pack_last),
    .job_done        (job_done),
    .job_done_ack    (job_done_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_relu(input logic [15:0] s);
`ifdef CNN_RESULT_PACKER_RELU_EN
    return s[15] ? 16'h0000 : s;
`else
    return s;
`endif
  endfunction

  // One clock: drive at negedge, observe, record handshakes, wait for posedge.
  task automatic step(input logic cv, input logic [31:0] cn, input logic rv,
                      input logic [15:0] rd, input logic pr, input logic ack);
    @(negedge clk_if);
    cfg_valid = cv; cfg_num_results = cn; result_valid = rv;
    result_data = rd; pack_ready = pr; job_done_ack = ack;
    #1;
    if (last_hs_prev) chk("job_done_after_last", 128'(job_done), 128'(1));
    if (stalled) begin
      chk("stall_valid", 128'(pack_valid), 128'(1));
      chk("stall_data", pack_data, held_data);
      chk("stall_keep", 128'(pack_keep), 128'(held_keep));
      chk("stall_last", 128'(pack_last), 128'(held_last));
    end
    obs_done    = job_done;
    obs_racc    = result_accept;
    obs_cfg_acc = cfg_accept;
    acc_now     = rv && result_accept;
    if (acc_now) acc_q.push_back(rd);
    last_hs_prev = 1'b0;
    stalled      = 1'b0;
    if (pack_valid) begin
      if (pr) begin
        out_data.push_back(pack_data);
        out_keep.push_back(pack_keep);
        out_last.push_back(pack_last);
        last_hs_prev = pack_last;
      end else begin
        stalled   = 1'b1;
        held_data = pack_data;
        held_keep = pack_keep;
        held_last = pack_last;
      end
    end
    @(posedge clk_if);
  endtask

  task automatic clear_model();
    acc_q.delete(); out_data.delete(); out_keep.delete(); out_last.delete();
    stalled = 1'b0; last_hs_prev = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_cfg_accept", 128'(cfg_accept), 128'(1));
    chk("rst_result_accept", 128'(result_accept), 128'(0));
    chk("rst_pack_valid", 128'(pack_valid), 128'(0));
    chk("rst_pack_last", 128'(pack_last), 128'(0));
    chk("rst_job_done", 128'(job_done), 128'(0));
    chk("rst_pack_keep", 128'(pack_keep), 128'(0));
    chk("rst_pack_data", pack_data, 128'(0));
  endtask

  // Run one job of n samples held in smp[]; compare against the chunking model.
  task automatic run_job(input int n, input int stall_len, input int rv_pct, input int pr_pct);
    int idx = 0;
    int cyc = 0;
    int nw;
    logic rv, pr;
    logic [127:0] ed;
    logic [7:0] ek;
    clear_model();
    chk("cfg_accept_idle", 128'(cfg_accept), 128'(1));
    step(1'b1, 32'(n), 1'b0, 16'h0, 1'b1, 1'b0);
    do begin
      if (cyc < stall_len) begin
        rv = (idx < n);
        pr = 1'b0;
      end else begin
        rv = (idx < n) && ($urandom_range(99) < 32'(rv_pct));
        pr = ($urandom_range(99) < 32'(pr_pct));
      end
      step(1'b0, 32'h0, rv, (idx < n) ? smp[idx] : 16'h0, pr, 1'b0);
      if (acc_now) idx++;
      cyc++;
      if (stall_len > 0 && cyc == stall_len) begin
        chk("stall_accepted", 128'(acc_q.size()), 128'((n < 16) ? n : 16));
        chk("stall_accept_low", 128'(obs_racc), 128'(n <= 16 ? obs_racc : 1'b0));
      end
    end while (!obs_done && cyc < 3000);
    chk("job_done_reached", 128'(job_done), 128'(1));
    if (n == 0) chk("zero_done_latency", 128'(cyc), 128'(1));
    chk("accept_count", 128'(acc_q.size()), 128'(n));
    for (int i = 0; i < n && i < acc_q.size(); i++)
      chk("accept_order", 128'(acc_q[i]), 128'(smp[i]));
    nw = (n + 7) / 8;
    chk("word_count", 128'(out_data.size()), 128'(nw));
    for (int w = 0; w < nw && w < out_data.size(); w++) begin
      ed = '0;
      ek = '0;
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < n) begin
          ed[l*16 +: 16] = ref_relu(smp[w*8 + l]);
          ek[l] = 1'b1;
        end
      end
      chk("word_data", out_data[w], ed);
      chk("word_keep", 128'(out_keep[w]), 128'(ek));
      chk("word_last", 128'(out_last[w]), 128'(w == nw - 1));
    end
    step(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("ack_cfg_accept", 128'(obs_cfg_acc), 128'(1));
    chk("ack_job_done", 128'(obs_done), 128'(0));
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (2) @(negedge clk_if);
    #1;
    check_reset_values();
    @(negedge clk_if);
    rst = 1'b1;

    // Full-word job: samples 1..16.
    for (int i = 0; i < 16; i++) smp[i] = 16'(i + 1);
    run_job(16, 0, 100, 100);

    // Partial final word: 0x0100..0x010A.
    for (int i = 0; i < 11; i++) smp[i] = 16'(16'h0100 + i);
    run_job(11, 0, 100, 100);

    // Backpressure: 32 samples, downstream stalled for 20 clocks.
    for (int i = 0; i < 32; i++) smp[i] = 16'($urandom);
    run_job(32, 20, 100, 100);

    // Zero count.
    run_job(0, 0, 100, 100);

    // Rectification boundary samples.
    smp[0] = 16'hFFF0;
    smp[1] = 16'h0005;
    smp[2] = 16'h8000;
    smp[3] = 16'h7FFF;
    run_job(4, 0, 100, 100);

    // Reset mid-job after 5 samples.
    for (int i = 0; i < 16; i++) smp[i] = 16'(16'h0A00 + i);
    clear_model();
    step(1'b1, 32'd16, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, smp[i], 1'b0, 1'b0);
    chk("pre_reset_accepted", 128'(acc_q.size()), 128'(5));
    @(negedge clk_if);
    result_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk_if);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) smp[i] = 16'(16'h0B00 + i);
    run_job(8, 0, 100, 100);

    // Randomized jobs with random valid/ready activity.
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) smp[i] = 16'($urandom);
      run_job(n, 0, 70, 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
